instr_fetch: RTL and testbench

//  Fetch stage of the X9 core. Owns the PC, drives the instruction ROM address and receives a

---
 rtl/instr_fetch_if.sv | 37 +++
 rtl/instr_fetch.sv | 112 +++++++++++
 tb/tb_instr_fetch.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus of the X9 core.
// Carries the program control inputs (Start/StartAddr/EndAddr), the decoder feedback
// (Stall, BranchInst, BranchCond, BranchTarget), the synchronous ROM port
// (InstAddr out, InstData back) and the delivered-instruction outputs
// (Instr, Opcode, InstPC, InstValid, Done).
//   master : the fetch stage (instr_fetch)
//   slave  : everything around it (decoder, ROM, sequencer)
interface instr_fetch_if #(
  parameter int PCW       = 10,
  parameter int IW        = 9,
  parameter int MCODEBITS = 5
);
  logic                 Start;
  logic [PCW-1:0]       StartAddr;
  logic [PCW-1:0]       EndAddr;
  logic                 Stall;
  logic                 BranchInst;
  logic                 BranchCond;
  logic [PCW-1:0]       BranchTarget;
  logic [PCW-1:0]       InstAddr;
  logic [IW-1:0]        InstData;
  logic [IW-1:0]        Instr;
  logic [MCODEBITS-1:0] Opcode;
  logic [PCW-1:0]       InstPC;
  logic                 InstValid;
  logic                 Done;

  modport master (
    input  Start, StartAddr, EndAddr, Stall, BranchInst, BranchCond, BranchTarget, InstData,
    output InstAddr, Instr, Opcode, InstPC, InstValid, Done
  );

  modport slave (
    output Start, StartAddr, EndAddr, Stall, BranchInst, BranchCond, BranchTarget, InstData,
    input  InstAddr, Instr, Opcode, InstPC, InstValid, Done
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage of the X9 core.
// Owns the PC, drives the synchronous instruction ROM and delivers one instruction per
// cycle to the decoder, honouring stalls, taken-branch redirects and a programmable
// end address.
// Ports:
//   Clk      rising-edge clock
//   Reset_n  asynchronous active-low reset
//   bus      instr_fetch_if.master (control in, ROM port, delivered instruction out)
module instr_fetch #(
  parameter int PCW       = 10,
  parameter int IW        = 9,
  parameter int MCODEBITS = 5
) (
  input  logic           Clk,
  input  logic           Reset_n,
  instr_fetch_if.master  bus
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t         state;
  logic [PCW-1:0] inst_addr;
  logic [PCW-1:0] inst_pc;
  logic           inst_valid;
  logic           done;
  logic [IW-1:0]  hold;
  logic           use_hold;
  logic [IW-1:0]  instr;

  logic retire;
  logic at_end;
  logic taken;

  // InstPC is loaded on the same edge the ROM samples InstAddr, so the ROM output
  // in the following cycle is the instruction at InstPC and is passed straight through.
  // While stalled (and in IDLE/DONE) the hold register stands in for the ROM; the
  // ROM re-reads the unchanged InstAddr on the edge that ends the stall.
  always_comb begin
    instr = use_hold ? hold : bus.InstData;
  end

  always_comb begin
    retire = inst_valid & ~bus.Stall;
    at_end = retire & (inst_pc == bus.EndAddr);
    taken  = retire & bus.BranchInst & bus.BranchCond;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      inst_addr  <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      done       <= 1'b0;
      hold       <= '0;
      use_hold   <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.Start) begin
            state      <= FILL;
            inst_addr  <= bus.StartAddr;
            inst_valid <= 1'b0;
            done       <= 1'b0;
          end
        end
        FILL: begin
          state      <= RUN;
          inst_pc    <= inst_addr;
          inst_addr  <= inst_addr + 1'b1;
          inst_valid <= 1'b1;
          use_hold   <= 1'b0;
        end
        RUN: begin
          if (bus.Stall) begin
            if (!use_hold) begin
              hold     <= bus.InstData;
              use_hold <= 1'b1;
            end
          end else if (at_end) begin
            // End retirement wins over a simultaneous taken branch; InstAddr freezes.
            state      <= DONE;
            done       <= 1'b1;
            inst_valid <= 1'b0;
            hold       <= instr;
            use_hold   <= 1'b1;
          end else if (taken) begin
            // The sequential fetch now in the ROM becomes the single bubble.
            inst_pc    <= inst_addr;
            inst_addr  <= bus.BranchTarget;
            inst_valid <= 1'b0;
            use_hold   <= 1'b0;
          end else begin
            inst_pc    <= inst_addr;
            inst_addr  <= inst_addr + 1'b1;
            inst_valid <= 1'b1;
            use_hold   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.InstAddr  = inst_addr;
  assign bus.InstPC    = inst_pc;
  assign bus.InstValid = inst_valid;
  assign bus.Done      = done;
  assign bus.Instr     = instr;
  assign bus.Opcode    = instr[IW-1 -: MCODEBITS];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by randomized
// programs, all compared against a program-order reference model.
module tb_instr_fetch;
  localparam int PCW = 10;
  localparam int IW  = 9;
  localparam logic [4:0] BEQ = 5'h1F;

  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_RUN  = 2;
  localparam int M_DONE = 3;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  instr_fetch_if #(.PCW(PCW), .IW(IW), .MCODEBITS(5)) bus ();

  instr_fetch #(.PCW(PCW), .IW(IW), .MCODEBITS(5)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.master)
  );

  logic [IW-1:0] mem [1024];
  always @(posedge Clk) bus.InstData <= mem[bus.InstAddr];

  int errors = 0;
  int checks = 0;

  // Reference model: where the program is and what must be on the outputs.
  int             m_mode;
  bit             m_valid;
  bit             m_done;
  logic [PCW-1:0] m_pc;    // PC of the delivered instruction (meaningful when m_valid)
  logic [PCW-1:0] m_next;  // next PC in program order, i.e. the ROM address

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_valid = 1'b0;
    m_done  = 1'b0;
    m_pc    = '0;
    m_next  = '0;
  endtask

  task automatic model_edge();
    case (m_mode)
      M_IDLE, M_DONE: begin
        if (bus.Start) begin
          m_mode  = M_FILL;
          m_next  = bus.StartAddr;
          m_done  = 1'b0;
          m_valid = 1'b0;
        end
      end
      M_FILL: begin
        m_pc    = m_next;
        m_next  = m_next + 1'b1;
        m_valid = 1'b1;
        m_mode  = M_RUN;
      end
      default: begin
        if (!bus.Stall) begin
          if (m_valid && m_pc == bus.EndAddr) begin
            m_mode  = M_DONE;
            m_done  = 1'b1;
            m_valid = 1'b0;
          end else if (m_valid && bus.BranchInst && bus.BranchCond) begin
            m_valid = 1'b0;
            m_next  = bus.BranchTarget;
          end else begin
            m_pc    = m_next;
            m_next  = m_next + 1'b1;
            m_valid = 1'b1;
          end
        end
      end
    endcase
  endtask

  task automatic compare();
    logic [IW-1:0] w;
    check("instaddr", bus.InstAddr, m_next);
    check("instvalid", bus.InstValid, m_valid);
    check("done", bus.Done, m_done);
    if (m_valid) begin
      w = mem[m_pc];
      check("instpc", bus.InstPC, m_pc);
      check("instr", bus.Instr, w);
      check("opcode", bus.Opcode, w[8:4]);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge Clk);
    @(negedge Clk);
    compare();
  endtask

  task automatic start_prog(input logic [PCW-1:0] s, input logic [PCW-1:0] e);
    bus.StartAddr = s;
    bus.EndAddr   = e;
    bus.Start     = 1'b1;
    cycle();
    bus.Start     = 1'b0;
  endtask

  // Asserts reset between clock edges and checks the outputs before the next edge.
  task automatic do_reset();
    #2 Reset_n = 1'b0;
    #1;
    check("rst_instaddr", bus.InstAddr, 0);
    check("rst_instpc", bus.InstPC, 0);
    check("rst_instr", bus.Instr, 0);
    check("rst_opcode", bus.Opcode, 0);
    check("rst_instvalid", bus.InstValid, 0);
    check("rst_done", bus.Done, 0);
    model_reset();
    @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // Decoder stand-in: flags beq on the delivered instruction.
  task automatic decode();
    bus.BranchInst = bus.InstValid && (bus.Instr[8:4] == BEQ);
  endtask

  task automatic default_rom();
    for (int a = 0; a < 1024; a++) mem[a] = 9'(a);
  endtask

  task automatic clear_inputs();
    bus.Start        = 1'b0;
    bus.Stall        = 1'b0;
    bus.BranchInst   = 1'b0;
    bus.BranchCond   = 1'b0;
    bus.BranchTarget = '0;
  endtask

  // Observed slot: InstPC when valid, all-ones for a bubble.
  function automatic logic [31:0] slot();
    return bus.InstValid ? 32'(bus.InstPC) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    logic [31:0] t2_exp [6];
    logic [31:0] t3_exp [6];
    logic [PCW-1:0] s, e;
    int len;

    clear_inputs();
    bus.StartAddr = '0;
    bus.EndAddr   = '0;
    default_rom();
    model_reset();
    @(negedge Clk);

    // 1: basic latency and back-to-back delivery
    do_reset();
    compare();
    start_prog(10'h010, 10'h3FF);
    check("t1_addr_lat", bus.InstAddr, 10'h010);
    cycle();
    check("t1_first_pc", bus.InstPC, 10'h010);
    check("t1_first_valid", bus.InstValid, 1);
    cycle();
    check("t1_pc1", slot(), 32'h011);
    cycle();
    check("t1_pc2", slot(), 32'h012);

    // 2: taken beq at 0x012 -> one bubble, then 0x040
    t2_exp = '{32'h010, 32'h011, 32'h012, 32'hFFFF_FFFF, 32'h040, 32'h041};
    do_reset();
    mem[10'h012]     = {BEQ, 4'h0};
    bus.BranchCond   = 1'b1;
    bus.BranchTarget = 10'h040;
    start_prog(10'h010, 10'h3FF);
    for (int i = 0; i < 6; i++) begin
      decode();
      cycle();
      check("t2_seq", slot(), t2_exp[i]);
    end

    // 3: not-taken beq -> no bubble
    t3_exp = '{32'h010, 32'h011, 32'h012, 32'h013, 32'h014, 32'h015};
    do_reset();
    bus.BranchCond = 1'b0;
    start_prog(10'h010, 10'h3FF);
    for (int i = 0; i < 6; i++) begin
      decode();
      cycle();
      check("t3_seq", slot(), t3_exp[i]);
    end

    // 4a: three stall cycles while 0x011 is delivered
    do_reset();
    bus.BranchInst = 1'b0;
    start_prog(10'h010, 10'h3FF);
    cycle();
    cycle();
    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t4_stall_pc", slot(), 32'h011);
    end
    bus.Stall = 1'b0;
    cycle();
    check("t4_after1", slot(), 32'h012);
    cycle();
    check("t4_after2", slot(), 32'h013);

    // 4b: stall while the branch bubble is on the outputs
    do_reset();
    bus.BranchCond   = 1'b1;
    bus.BranchTarget = 10'h040;
    start_prog(10'h010, 10'h3FF);
    for (int i = 0; i < 9; i++) begin
      decode();
      bus.Stall = (i == 4 || i == 5);
      cycle();
    end
    bus.Stall = 1'b0;
    check("t4b_resume", slot(), 32'h042);
    mem[10'h012] = 9'h012;
    clear_inputs();

    // 5: end address, Done level, restart from DONE
    do_reset();
    start_prog(10'h010, 10'h015);
    for (int i = 0; i < 9; i++) cycle();
    check("t5_done", bus.Done, 1);
    check("t5_frozen", bus.InstAddr, 10'h016);
    start_prog(10'h020, 10'h025);
    check("t5_done_clr", bus.Done, 0);
    cycle();
    check("t5_restart_pc", slot(), 32'h020);
    cycle();

    // 6: asynchronous reset mid-run, then a wrapping program
    do_reset();
    start_prog(10'h3FE, 10'h001);
    for (int i = 0; i < 7; i++) cycle();
    check("t6_wrap_done", bus.Done, 1);

    // Randomized programs
    for (int a = 0; a < 1024; a++) mem[a] = 9'($urandom);
    for (int p = 0; p < 10; p++) begin
      if (m_mode != M_IDLE && m_mode != M_DONE) do_reset();
      s   = 10'($urandom);
      len = $urandom_range(0, 40);
      e   = s + 10'(len);
      start_prog(s, e);
      for (int c = 0; c < 70; c++) begin
        bus.Stall        = ($urandom_range(0, 3) == 0);
        bus.BranchInst   = ($urandom_range(0, 4) == 0);
        bus.BranchCond   = 1'($urandom);
        bus.BranchTarget = s + 10'($urandom_range(0, len));
        bus.Start        = ($urandom_range(0, 15) == 0);
        bus.StartAddr    = s + 10'($urandom_range(0, len));
        cycle();
      end
      clear_inputs();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
